// File: rtl/compare_arbiter.sv
// -----------------------------------------------------------------------------
// compare_arbiter
//   Shares one signed magnitude comparator (Compare) between two requesters.
//   Requests are arbitrated round-robin, operands are latched on acceptance,
//   the comparator runs for exactly one cycle and the registered result
//   {more, equal, less} is returned through a valid/ready response handshake.
//
//   Optional feature macro: CMP_UNSIGNED_EN
//     When defined, adds req0_unsigned / req1_unsigned. A latched 1 selects an
//     unsigned compare by flipping both operand MSBs before Compare.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_valid/ready        request handshake (ready is combinational)
//   req{0,1}_a, req{0,1}_b      operands
//   req{0,1}_unsigned           unsigned select (CMP_UNSIGNED_EN only)
//   rsp{0,1}_valid/ready        response handshake
//   rsp_flags                   shared result {a>b, a==b, a<b}
//   busy                        FSM is in CMP or RESP
//   cmp_count                   completed response handshakes (wraps)
// -----------------------------------------------------------------------------

// Signed magnitude comparator shared by the arbiter.
module Compare #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             more,
  output logic             equal,
  output logic             less
);
  assign more  = $signed(a) >  $signed(b);
  assign equal = a == b;
  assign less  = $signed(a) <  $signed(b);
endmodule

module compare_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
`ifdef CMP_UNSIGNED_EN
  input  logic                  req0_unsigned,
  input  logic                  req1_unsigned,
`endif
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [2:0]            rsp_flags,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  cmp_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  rr_ptr;    // preferred id when both request
  logic                  grant_id;  // id being served
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  winner;
  logic                  accept;
  logic                  rsp_hs;
  logic                  cmp_more;
  logic                  cmp_equal;
  logic                  cmp_less;
  logic [DATA_WIDTH-1:0] cmp_a;
  logic [DATA_WIDTH-1:0] cmp_b;

  // Arbitration: a lone requester always wins, otherwise rr_ptr decides.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    winner     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = rr_ptr;
    end else begin
      winner = req1_valid;
    end
    if (rst_n && state == IDLE) begin
      req0_ready = req0_valid && !winner;
      req1_ready = req1_valid &&  winner;
    end
  end

  assign accept = req0_ready || req1_ready;
  assign rsp_hs = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

`ifdef CMP_UNSIGNED_EN
  logic uns_q;

  // Flipping both MSBs maps unsigned ordering onto signed ordering.
  assign cmp_a = {a_q[DATA_WIDTH-1] ^ uns_q, a_q[DATA_WIDTH-2:0]};
  assign cmp_b = {b_q[DATA_WIDTH-1] ^ uns_q, b_q[DATA_WIDTH-2:0]};
`else
  assign cmp_a = a_q;
  assign cmp_b = b_q;
`endif

  Compare #(
    .WIDTH (DATA_WIDTH)
  ) u_compare (
    .a     (cmp_a),
    .b     (cmp_b),
    .more  (cmp_more),
    .equal (cmp_equal),
    .less  (cmp_less)
  );

  // Operand registers are only consumed after an acceptance has loaded them.
  // NOTE: pure datapath registers are deliberately left without reset; the
  // control state guarantees they are written before they are read.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= winner ? req1_a : req0_a;
      b_q <= winner ? req1_b : req0_b;
`ifdef CMP_UNSIGNED_EN
      uns_q <= winner ? req1_unsigned : req0_unsigned;
`endif
    end
  end

  // Control FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      grant_id   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_flags  <= 3'b000;
      busy       <= 1'b0;
      cmp_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant_id <= winner;
            busy     <= 1'b1;
            state    <= CMP;
          end
        end
        CMP: begin
          rsp_flags  <= {cmp_more, cmp_equal, cmp_less};
          rsp0_valid <= !grant_id;
          rsp1_valid <=  grant_id;
          state      <= RESP;
        end
        RESP: begin
          // Only the granted id's ready matters; rspN_valid is 0 otherwise.
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            rr_ptr     <= !grant_id;
            cmp_count  <= cmp_count + CNT_WIDTH'(1);
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
